fft_frame_ctrl: RTL and testbench

- Sequences the FFT core (AXI4-Stream config, data and output channels) one frame at a time.
- Flow for each command:
  - Accepts a transform-length command.
  - Builds and issues the 24-bit config word, including the length-dependent scaling schedule.
  - Gates the sample source into the core and generates tlast at point N-1.
  - Waits for the output frame's tlast, then reports done.
- Sits between the sample source/host control logic and the FFT core.

---
 rtl/fft_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: runs the FFT core one frame at a time.
// Issues config, gates samples, marks tlast, waits for output tlast.
module fft_frame_ctrl #(
  parameter int         MAX_LOG2N = 12,
  parameter int         DATA_W    = 32,
  parameter logic [4:0] FWD_FIELD = 5'b10000,
  parameter int         TIMEOUT   = 65535
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_log2n,
  input  logic [DATA_W-1:0] src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic [23:0]       fft_cfg_tdata,
  output logic              fft_cfg_tvalid,
  input  logic              fft_cfg_tready,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tvalid,
  input  logic              fft_tready,
  output logic              fft_tlast,
  input  logic              out_tvalid,
  input  logic              out_tready,
  input  logic              out_tlast,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              err_len,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int CW   = MAX_LOG2N + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    DATA,
    DRAIN
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [3:0]        log2n_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last_idx;
  logic [WD_W-1:0]   wd;
  logic              len_ok;
  logic              len_bad;
  logic              out_fire;
  logic              wd_hit;
  logic              dat_fire;

  function automatic logic [11:0] sch_of(input logic [3:0] n);
    logic [11:0] s;
    case (n)
      4'd3:    s = 12'd6;
      4'd4:    s = 12'd10;
      4'd5:    s = 12'd26;
      4'd6:    s = 12'd42;
      4'd7:    s = 12'd106;
      4'd8:    s = 12'd170;
      4'd9:    s = 12'd426;
      4'd10:   s = 12'd682;
      4'd11:   s = 12'd1706;
      default: s = 12'd2730;
    endcase
    return s;
  endfunction

  assign len_ok   = (cmd_log2n >= 4'd3) &&
                    (int'(cmd_log2n) <= MAX_LOG2N);
  assign len_bad  = (state == IDLE) && cmd_valid && !len_ok;
  assign out_fire = (state == DRAIN) && out_tvalid &&
                    out_tready && out_tlast;
  assign wd_hit   = (state == DRAIN) && !out_fire &&
                    (wd == WD_W'(TIMEOUT - 1));
  assign last_idx = (CW'(1) << log2n_q) - CW'(1);
  assign dat_fire = fft_tvalid && fft_tready;
  assign fft_tdata = src_tdata;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= nxt;
  end

  // Next state and pass-through gating.
  always_comb begin
    nxt        = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    fft_tvalid = 1'b0;
    src_tready = 1'b0;
    fft_tlast  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && len_ok) nxt = CFG;
      end
      CFG: begin
        if (fft_cfg_tvalid && fft_cfg_tready) nxt = DATA;
      end
      DATA: begin
        fft_tvalid = src_tvalid;
        src_tready = fft_tready;
        fft_tlast  = (cnt == last_idx);
        if (dat_fire && fft_tlast) nxt = DRAIN;
      end
      DRAIN: begin
        if (out_fire || wd_hit) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Config word, beat counter, watchdog, frame count and error flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      log2n_q        <= '0;
      fft_cfg_tdata  <= '0;
      fft_cfg_tvalid <= 1'b0;
      cnt            <= '0;
      wd             <= '0;
      done           <= 1'b0;
      frame_cnt      <= '0;
      err_len        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            log2n_q <= cmd_log2n;
            if (len_ok) begin
              fft_cfg_tdata  <= {3'b000, sch_of(cmd_log2n),
                                 FWD_FIELD, cmd_log2n};
              fft_cfg_tvalid <= 1'b1;
            end
          end
        end
        CFG: begin
          if (fft_cfg_tvalid && fft_cfg_tready) begin
            fft_cfg_tvalid <= 1'b0;
            cnt            <= '0;
          end
        end
        DATA: begin
          if (dat_fire) cnt <= cnt + CW'(1);
        end
        DRAIN: begin
          if (out_fire) begin
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            wd        <= '0;
          end else if (wd_hit) begin
            wd <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: ;
      endcase
      err_len     <= len_bad | (err_len & ~err_clr);
      err_timeout <= wd_hit | (err_timeout & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized frames checked against a
// frame-level model (config formula, beat scoreboard, timeout).
module tb_fft_frame_ctrl;

  localparam int TO = 100;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_log2n = '0;
  logic [31:0] src_tdata = '0;
  logic        src_tvalid = 1'b0;
  logic        src_tready;
  logic [23:0] fft_cfg_tdata;
  logic        fft_cfg_tvalid;
  logic        fft_cfg_tready = 1'b0;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tready = 1'b0;
  logic        fft_tlast;
  logic        out_tvalid = 1'b0;
  logic        out_tready = 1'b0;
  logic        out_tlast = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;
  logic        err_len;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int exp_frames = 0;
  int sch_tab [16] = '{0, 0, 0, 6, 10, 26, 42, 106, 170,
                       426, 682, 1706, 2730, 2730, 2730, 2730};

  always #5 aclk = ~aclk;

  fft_frame_ctrl #(
    .MAX_LOG2N(12),
    .DATA_W(32),
    .FWD_FIELD(5'b10000),
    .TIMEOUT(TO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_log2n(cmd_log2n),
    .src_tdata(src_tdata),
    .src_tvalid(src_tvalid),
    .src_tready(src_tready),
    .fft_cfg_tdata(fft_cfg_tdata),
    .fft_cfg_tvalid(fft_cfg_tvalid),
    .fft_cfg_tready(fft_cfg_tready),
    .fft_tdata(fft_tdata),
    .fft_tvalid(fft_tvalid),
    .fft_tready(fft_tready),
    .fft_tlast(fft_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast(out_tlast),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] cfg_word(input int n);
    logic [11:0] s;
    logic [3:0]  l;
    s = 12'(sch_tab[n]);
    l = 4'(n);
    return {3'b000, s, 5'b10000, l};
  endfunction

  task automatic send_cmd(input int n);
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_log2n = 4'(n);
    #1 chk("cmd_ready", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic bad_cmd(input int n);
    send_cmd(n);
    #1;
    chk("err_len_set", err_len, 1);
    chk("bad_busy", busy, 0);
    chk("bad_cfg_valid", fft_cfg_tvalid, 0);
  endtask

  task automatic clear_errs();
    @(negedge aclk);
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    #1;
    chk("clr_len", err_len, 0);
    chk("clr_to", err_timeout, 0);
  endtask

  task automatic stray_out();
    @(negedge aclk);
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b1;
    @(negedge aclk);
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    out_tlast  = 1'b0;
    #1;
    chk("stray_done", done, 0);
    chk("stray_cnt", frame_cnt, 16'(exp_frames));
  endtask

  task automatic run_frame(input int n, input int stall, input bit gaps,
                           input bit withhold, input int rst_at);
    int  nn;
    int  k;
    int  guard;
    int  d;
    bit  fired;
    nn = 1 << n;
    k = 0;
    send_cmd(n);
    guard = 0;
    fired = 1'b0;
    while (!fired && guard < stall + 10) begin
      fft_cfg_tready = (guard >= stall);
      #1;
      chk("cfg_valid", fft_cfg_tvalid, 1);
      chk("cfg_data", fft_cfg_tdata, cfg_word(n));
      chk("cfg_src_rdy", src_tready, 0);
      chk("cfg_fft_valid", fft_tvalid, 0);
      fired = fft_cfg_tvalid && fft_cfg_tready;
      guard++;
      @(negedge aclk);
    end
    fft_cfg_tready = 1'b0;
    if (!fired) chk("cfg_handshake", 0, 1);
    guard = 0;
    while (k < nn && guard < 8 * nn + 50) begin
      if (rst_at >= 0 && k == rst_at) begin
        src_tvalid = 1'b1;
        fft_tready = 1'b1;
        #1 aresetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fft_valid", fft_tvalid, 0);
        chk("rst_src_rdy", src_tready, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        src_tvalid = 1'b0;
        fft_tready = 1'b0;
        exp_frames = 0;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("rst_done", done, 0);
          chk("rst_frames", frame_cnt, 0);
          chk("rst_idle", cmd_ready, 1);
          @(negedge aclk);
        end
        return;
      end
      src_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      fft_tready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      src_tdata  = $urandom;
      #1;
      chk("fwd_valid", fft_tvalid, src_tvalid);
      chk("fwd_ready", src_tready, fft_tready);
      chk("fwd_data", fft_tdata, src_tdata);
      chk("cfg_dropped", fft_cfg_tvalid, 0);
      if (src_tvalid && fft_tready) begin
        chk("tlast", fft_tlast, k == nn - 1);
        k++;
      end
      guard++;
      @(negedge aclk);
    end
    src_tvalid = 1'b0;
    fft_tready = 1'b0;
    chk("data_beats", k, nn);
    if (withhold) begin
      for (int i = 0; i < TO; i++) begin
        #1;
        chk("drain_busy", busy, 1);
        chk("drain_to", err_timeout, 0);
        chk("drain_done", done, 0);
        @(negedge aclk);
      end
      #1;
      chk("to_busy", busy, 0);
      chk("to_flag", err_timeout, 1);
      chk("to_done", done, 0);
      chk("to_frames", frame_cnt, 16'(exp_frames));
    end else begin
      d = $urandom_range(0, 6);
      for (int i = 0; i < d; i++) begin
        out_tlast  = 1'b1;
        out_tvalid = $urandom_range(0, 1);
        out_tready = !out_tvalid;
        #1;
        chk("wait_busy", busy, 1);
        chk("wait_done", done, 0);
        @(negedge aclk);
      end
      out_tvalid = 1'b1;
      out_tready = 1'b1;
      out_tlast  = 1'b1;
      #1 chk("pre_done", done, 0);
      @(negedge aclk);
      out_tvalid = 1'b0;
      out_tready = 1'b0;
      out_tlast  = 1'b0;
      exp_frames++;
      #1;
      chk("done", done, 1);
      chk("frames", frame_cnt, 16'(exp_frames));
      chk("idle_after", busy, 0);
      @(negedge aclk);
      #1 chk("done_once", done, 0);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_cmd_ready0", cmd_ready, 1);
    chk("rst_busy0", busy, 0);
    chk("rst_cfgv0", fft_cfg_tvalid, 0);
    chk("rst_cfgd0", fft_cfg_tdata, 0);
    chk("rst_done0", done, 0);
    chk("rst_frames0", frame_cnt, 0);
    chk("rst_errs0", {err_len, err_timeout}, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    run_frame(9, 0, 1'b0, 1'b0, -1);
    run_frame(10, 5, 1'b0, 1'b0, -1);
    run_frame(4, 0, 1'b1, 1'b0, -1);
    stray_out();

    #1 chk("len_clean", err_len, 0);
    bad_cmd(2);
    bad_cmd(13);
    clear_errs();
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_log2n = 4'd0;
    err_clr   = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    #1 chk("set_wins", err_len, 1);
    clear_errs();

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 15);
      if (n >= 3 && n <= 12) begin
        n = 3 + (n % 5);
        run_frame(n, $urandom_range(0, 3), 1'b1, 1'b0, -1);
      end else begin
        bad_cmd(n);
        clear_errs();
      end
    end

    run_frame(3, 0, 1'b0, 1'b1, -1);
    run_frame(5, 1, 1'b1, 1'b0, -1);
    #1 chk("to_sticky", err_timeout, 1);
    clear_errs();

    run_frame(9, 0, 1'b0, 1'b0, 200);
    run_frame(3, 2, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
